ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DW, default 4, data width of each storage word.
REQ-002 Parameter AW, default 2, address width; depth = 2**AW words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req0  input  1  port 0 access request; held high until ack0.
REQ-006 we0  input  1  port 0 write enable (1 write, 0 read).
REQ-007 addr0  input  AW  port 0 word address.
REQ-008 wdata0  input  DW  port 0 write data.
REQ-009 req1, we1, addr1, wdata1  input  1/1/AW/DW  port 1 equivalents.
REQ-010 ack0  output  1  registered, single-cycle completion pulse for port 0.
REQ-011 ack1  output  1  registered, single-cycle completion pulse for port 1.
REQ-012 rdata  output  DW  registered read data; valid in the cycle ack0 or ack1 is high for a read.
REQ-013 busy  output  1  high while in ACCESS state.
REQ-014 mem_view  output  DW*2**AW  live contents of all words; word i at bits [i*DW +: DW], for LED display.

Function
REQ-015 Storage: 2**AW words of DW bits, internal to the block; only the arbiter writes it.
REQ-016 FSM states: IDLE, ACCESS; one access per two cycles max.
REQ-017 Eligibility in IDLE: port n eligible when reqn=1 and ackn=0 in that cycle (a request being acknowledged is never re-granted on the ack cycle).
REQ-018 IDLE, no eligible port: stay IDLE, nothing latched.
REQ-019 IDLE, one eligible port: latch its we/addr/wdata and the winner index, go to ACCESS.
REQ-020 IDLE, both eligible: grant the port not served last (round-robin pointer last); latch and go to ACCESS.
REQ-021 ACCESS: on the edge leaving ACCESS, perform the latched operation, set ack of the winner to 1 for exactly the next cycle, update last to the winner, return to IDLE.
REQ-022 Write: mem[addr] <= wdata at the ACCESS exit edge; rdata unchanged.
REQ-023 Read: rdata <= mem[addr] at the ACCESS exit edge; value persists until the next read completes.
REQ-024 Latency: request seen eligible in cycle N -> ACCESS in N+1 -> ack high in N+2.
REQ-025 ack0 and ack1 are never high in the same cycle; ack is 0 in all other cycles.
REQ-026 Request inputs are ignored in ACCESS; changes to we/addr/wdata after the IDLE latch edge have no effect.
REQ-027 Back-to-back same port: requester holding req high after ack is eligible again in the cycle after the ack cycle.
REQ-028 Read of a word written by the immediately preceding access returns the new value.
REQ-029 mem_view reflects writes from the cycle after the write edge.

Reset
REQ-030 rst=1: state IDLE, ack0=0, ack1=0, rdata=0, busy=0, all storage words 0, last=1 (port 0 wins first tie).
REQ-031 rst asserted while in ACCESS: latched operation discarded, no write, no ack.
REQ-032 rst has priority over every other input in the same cycle.

Verification
REQ-033 After reset, req0=1 we0=1 addr0=2 wdata0=0xA -> ack0 high exactly 2 cycles later, mem_view word2=0xA, all others 0.
REQ-034 Then req1=1 we1=0 addr1=2 -> ack1 pulse 2 cycles later with rdata=0xA; ack0 stays 0.
REQ-035 req0 and req1 both rise in the same cycle (writes 0x1 to addr0, 0x2 to addr1) -> ack0 first, ack1 two cycles later (3-cycle spacing from ack0 is an error; exactly 2 required), next tie goes to port 0.
REQ-036 Both ports hold req high continuously for 8 accesses -> acks alternate 0,1,0,1,... one every 2 cycles, never simultaneous.
REQ-037 Port 0 write 0x5 to addr3 with rst pulsed in the ACCESS cycle -> no ack0, mem word3 remains 0, busy 0 after reset.
REQ-038 Write 0xF to addr1 then immediately read addr1 from the same port -> rdata=0xF on the second ack.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Two-port request/ack bus for ram_arbiter, plus read data, busy flag and the
// flattened storage view used for LED display.
interface ram_arbiter_if #(
  parameter int DW = 4,
  parameter int AW = 2
);
  logic                   req0;
  logic                   we0;
  logic [AW-1:0]          addr0;
  logic [DW-1:0]          wdata0;
  logic                   req1;
  logic                   we1;
  logic [AW-1:0]          addr1;
  logic [DW-1:0]          wdata1;
  logic                   ack0;
  logic                   ack1;
  logic [DW-1:0]          rdata;
  logic                   busy;
  logic [DW*(2**AW)-1:0]  mem_view;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata, busy, mem_view
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, ack1, rdata, busy, mem_view
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter in front of a small register-file RAM.
// One access every two cycles: IDLE latches the winner, ACCESS performs it.
module ram_arbiter #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input logic         clk,
  input logic         rst,
  ram_arbiter_if.slave bus
);
  localparam int unsigned Depth = 2**AW;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  state_t        stateNext;

  logic [DW-1:0] mem [Depth];
  logic          ack0Q;
  logic          ack1Q;
  logic [DW-1:0] rdataQ;
  logic          last;

  logic          winner;
  logic          opWe;
  logic [AW-1:0] opAddr;
  logic [DW-1:0] opWdata;

  logic          elig0;
  logic          elig1;
  logic          grant;
  logic          grantPort;

  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    grantPort = 1'b0;
    // A port whose ack is showing this cycle is not re-granted yet.
    elig0     = bus.req0 & ~ack0Q;
    elig1     = bus.req1 & ~ack1Q;
    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          grant     = 1'b1;
          grantPort = (elig0 & elig1) ? ~last : elig1;
          stateNext = ACCESS;
        end
      end
      ACCESS:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack0Q   <= 1'b0;
      ack1Q   <= 1'b0;
      rdataQ  <= '0;
      last    <= 1'b1;
      winner  <= 1'b0;
      opWe    <= 1'b0;
      opAddr  <= '0;
      opWdata <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      ack0Q <= 1'b0;
      ack1Q <= 1'b0;
      if (grant) begin
        winner  <= grantPort;
        opWe    <= grantPort ? bus.we1    : bus.we0;
        opAddr  <= grantPort ? bus.addr1  : bus.addr0;
        opWdata <= grantPort ? bus.wdata1 : bus.wdata0;
      end
      if (state == ACCESS) begin
        if (opWe) mem[opAddr] <= opWdata;
        else      rdataQ      <= mem[opAddr];
        ack0Q <= ~winner;
        ack1Q <= winner;
        last  <= winner;
      end
    end
  end

  assign bus.ack0  = ack0Q;
  assign bus.ack1  = ack1Q;
  assign bus.rdata = rdataQ;
  assign bus.busy  = (state == ACCESS);

  for (genvar g = 0; g < Depth; g++) begin : gView
    assign bus.mem_view[g*DW +: DW] = mem[g];
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level reference model with
// per-cycle output comparison plus directed scenarios with literal expectations.
module tb_ram_arbiter;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int NW = 2**AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DW(DW), .AW(AW)) bus ();
  ram_arbiter #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction at a time, resolved one
  // edge after it is accepted; the ack is visible for the following cycle.
  logic [DW-1:0] mMem [NW];
  logic          mAck0 = 1'b0, mAck1 = 1'b0;
  logic [DW-1:0] mRdata = '0;
  int            mLast = 1;
  bit            pend = 1'b0;
  int            pPort;
  logic          pWe;
  logic [AW-1:0] pAddr;
  logic [DW-1:0] pData;
  bit            e0, e1;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) mMem[i] = '0;
      mAck0 = 1'b0; mAck1 = 1'b0; mRdata = '0; mLast = 1; pend = 1'b0;
    end else begin
      e0 = bus.req0 && !mAck0;
      e1 = bus.req1 && !mAck1;
      mAck0 = 1'b0; mAck1 = 1'b0;
      if (pend) begin
        if (pWe) mMem[pAddr] = pData;
        else     mRdata = mMem[pAddr];
        if (pPort == 0) mAck0 = 1'b1; else mAck1 = 1'b1;
        mLast = pPort;
        pend = 1'b0;
      end else if (e0 || e1) begin
        pPort = (e0 && e1) ? 1 - mLast : (e0 ? 0 : 1);
        pWe   = pPort == 0 ? bus.we0    : bus.we1;
        pAddr = pPort == 0 ? bus.addr0  : bus.addr1;
        pData = pPort == 0 ? bus.wdata0 : bus.wdata1;
        pend  = 1'b1;
      end
    end
  end

  function automatic logic [DW*NW-1:0] modelView();
    logic [DW*NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = mMem[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      check("ack0", bus.ack0, mAck0);
      check("ack1", bus.ack1, mAck1);
      check("rdata", bus.rdata, mRdata);
      check("busy", bus.busy, pend);
      check("mem_view", bus.mem_view, modelView());
      check("ack_exclusive", bus.ack0 & bus.ack1, 1'b0);
    end
  end

  task automatic doOp(input int port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output int lat, output logic [DW-1:0] rd);
    @(posedge clk); #1;
    lat = -1; rd = '0;
    if (port == 0) begin bus.req0 = 1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; end
    else           begin bus.req1 = 1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        lat = i; rd = bus.rdata; break;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    if (lat < 0) begin errors++; $display("FAIL timeout: no ack for port %0d", port); end
  endtask

  task automatic tie(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     output int t0, output int t1, output logic [DW-1:0] r0, output logic [DW-1:0] r1);
    bit done0, done1;
    @(posedge clk); #1;
    t0 = -1; t1 = -1; r0 = '0; r1 = '0; done0 = 0; done1 = 0;
    bus.req0 = 1; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = 1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.ack0 && !done0) begin t0 = i; r0 = bus.rdata; bus.req0 = 0; done0 = 1; end
      if (bus.ack1 && !done1) begin t1 = i; r1 = bus.rdata; bus.req1 = 0; done1 = 1; end
      if (done0 && done1) break;
    end
    bus.req0 = 0; bus.req1 = 0;
    if (!(done0 && done1)) begin errors++; $display("FAIL timeout: tie not completed"); end
  endtask

  int lat, t0, t1;
  logic [DW-1:0] rd, r0, r1;
  int seqPort [8];
  int seqTime [8];
  int nAck;

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    @(posedge clk); #1; checkEn = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", bus.ack0, 1'b0);
    check("rst_ack1", bus.ack1, 1'b0);
    check("rst_rdata", bus.rdata, 4'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mem_view", bus.mem_view, 16'h0000);
    rst = 0;

    // Write then read back from the other port.
    doOp(0, 1'b1, 2'd2, 4'hA, lat, rd);
    check("wr_latency", lat, 2);
    check("wr_mem_view", bus.mem_view, 16'h0A00);
    doOp(1, 1'b0, 2'd2, 4'h0, lat, rd);
    check("rd_latency", lat, 2);
    check("rd_data", rd, 4'hA);

    // Simultaneous requests: port 0 wins the tie, port 1 exactly two cycles later.
    tie(1'b1, 2'd0, 4'h1, 1'b1, 2'd1, 4'h2, t0, t1, r0, r1);
    check("tie1_t0", t0, 2);
    check("tie1_t1", t1, 4);
    check("tie1_mem_view", bus.mem_view, 16'h0A21);
    tie(1'b0, 2'd0, 4'h0, 1'b0, 2'd1, 4'h0, t0, t1, r0, r1);
    check("tie2_t0", t0, 2);
    check("tie2_t1", t1, 4);
    check("tie2_r0", r0, 4'h1);
    check("tie2_r1", r1, 4'h2);

    // Continuous contention: strict alternation, one ack every two cycles.
    @(posedge clk); #1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 2'd2;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2'd0;
    nAck = 0;
    for (int i = 1; i <= 40 && nAck < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack0 || bus.ack1) begin
        seqPort[nAck] = bus.ack1 ? 1 : 0;
        seqTime[nAck] = i;
        nAck++;
        if (nAck == 8) begin bus.req0 = 0; bus.req1 = 0; end
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    check("stream_count", nAck, 8);
    for (int k = 0; k < nAck; k++) begin
      check("stream_port", seqPort[k], k % 2);
      check("stream_time", seqTime[k], 2 * (k + 1));
    end

    // Reset during ACCESS discards the pending write.
    @(posedge clk); #1;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2'd3; bus.wdata0 = 4'h5;
    @(posedge clk); #1;
    check("abort_busy", bus.busy, 1'b1);
    rst = 1; bus.req0 = 0;
    @(posedge clk); #1;
    check("abort_ack0", bus.ack0, 1'b0);
    check("abort_busy_after", bus.busy, 1'b0);
    check("abort_mem_view", bus.mem_view, 16'h0000);
    rst = 0;

    // Write then immediately read the same word from the same port.
    doOp(0, 1'b1, 2'd1, 4'hF, lat, rd);
    check("raw_wr_latency", lat, 2);
    doOp(0, 1'b0, 2'd1, 4'h0, lat, rd);
    check("raw_rd_latency", lat, 2);
    check("raw_rd_data", rd, 4'hF);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
